// File: rtl/calendar_date_unit.sv
// calendar_date_unit: date / month / year-offset calendar stage fed by the
// day counter's midnight carry. Registers load from the shared 6-bit databus
// in three beats (date, month, year), then a validate beat clamps and commits.
// Optional macro CAL_LEAP_YEAR_EN: when defined, February has 29 days in years
// with year[1:0]==0; when undefined, February is always 28 days and no leap
// logic is built.
module calendar_date_unit #(
    parameter logic [4:0] RESET_DATE  = 5'd1,
    parameter logic [3:0] RESET_MONTH = 4'd1,
    parameter logic [5:0] RESET_YEAR  = 6'd0
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       clear,
    input  logic       load,
    input  logic       enable,
    input  logic [5:0] databus,
    input  logic       day_carry,
    output logic [4:0] date,
    output logic [3:0] month,
    output logic [5:0] year,
    output logic       month_carry,
    output logic       year_carry,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LD_MONTH = 2'd1;
    localparam logic [1:0] ST_LD_YEAR  = 2'd2;
    localparam logic [1:0] ST_VALIDATE = 2'd3;

`ifdef CAL_LEAP_YEAR_EN
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        logic [4:0] len;
        case (m)
            4'd2:                      len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
            default:                   len = 5'd31;
        endcase
        return len;
    endfunction
`else
    function automatic logic [4:0] month_len(input logic [3:0] m);
        logic [4:0] len;
        case (m)
            4'd2:                      len = 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
            default:                   len = 5'd31;
        endcase
        return len;
    endfunction
`endif

    logic [1:0] state_r,        state_s;
    logic [4:0] shadow_date_r,  shadow_date_s;
    logic [3:0] shadow_month_r, shadow_month_s;
    logic [5:0] shadow_year_r,  shadow_year_s;
    logic       pending_r,      pending_s;
    logic [4:0] date_r,         date_s;
    logic [3:0] month_r,        month_s;
    logic [5:0] year_r,         year_s;
    logic       month_carry_r,  month_carry_s;
    logic       year_carry_r,   year_carry_s;
    logic       busy_r;

    logic       tick_s;
    logic [4:0] cur_len_s;
    logic [4:0] commit_len_s;
    logic [3:0] commit_month_s;
    logic [4:0] commit_date_s;
    logic [4:0] inc_date_s;
    logic [3:0] inc_month_s;
    logic [5:0] inc_year_s;
    logic       inc_mc_s;
    logic       inc_yc_s;

    assign tick_s = day_carry & enable;

    // An out-of-range month commits as January before its length is looked up.
    assign commit_month_s = ((shadow_month_r == 4'd0) || (shadow_month_r > 4'd12)) ?
                            4'd1 : shadow_month_r;

`ifdef CAL_LEAP_YEAR_EN
    assign cur_len_s    = month_len(month_r, year_r[1:0] == 2'd0);
    assign commit_len_s = month_len(commit_month_s, shadow_year_r[1:0] == 2'd0);
`else
    assign cur_len_s    = month_len(month_r);
    assign commit_len_s = month_len(commit_month_s);
`endif

    // Clamp the loaded date into 1..length of the committed month.
    always_comb begin
        if (shadow_date_r == 5'd0) begin
            commit_date_s = 5'd1;
        end else if (shadow_date_r > commit_len_s) begin
            commit_date_s = commit_len_s;
        end else begin
            commit_date_s = shadow_date_r;
        end
    end

    // One-day advance of the current calendar, with month/year rollover.
    always_comb begin
        inc_date_s  = date_r;
        inc_month_s = month_r;
        inc_year_s  = year_r;
        inc_mc_s    = 1'b0;
        inc_yc_s    = 1'b0;
        if (date_r < cur_len_s) begin
            inc_date_s = date_r + 5'd1;
        end else begin
            inc_date_s = 5'd1;
            inc_mc_s   = 1'b1;
            if (month_r == 4'd12) begin
                inc_month_s = 4'd1;
                inc_year_s  = year_r + 6'd1;
                inc_yc_s    = (year_r == 6'd63);
            end else begin
                inc_month_s = month_r + 4'd1;
            end
        end
    end

    // Next-state: clear beats load, load beats counting; ticks arriving while
    // the load sequence owns the registers are parked in a one-deep pending flag.
    always_comb begin
        state_s        = state_r;
        shadow_date_s  = shadow_date_r;
        shadow_month_s = shadow_month_r;
        shadow_year_s  = shadow_year_r;
        pending_s      = pending_r;
        date_s         = date_r;
        month_s        = month_r;
        year_s         = year_r;
        month_carry_s  = 1'b0;
        year_carry_s   = 1'b0;
        if (clear) begin
            state_s        = ST_IDLE;
            shadow_date_s  = 5'd0;
            shadow_month_s = 4'd0;
            shadow_year_s  = 6'd0;
            pending_s      = 1'b0;
            date_s         = RESET_DATE;
            month_s        = RESET_MONTH;
            year_s         = RESET_YEAR;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        shadow_date_s = databus[4:0];
                        state_s       = ST_LD_MONTH;
                        pending_s     = pending_r | tick_s;
                    end else if (pending_r | tick_s) begin
                        date_s        = inc_date_s;
                        month_s       = inc_month_s;
                        year_s        = inc_year_s;
                        month_carry_s = inc_mc_s;
                        year_carry_s  = inc_yc_s;
                        // A pending tick is consumed now; a fresh one takes its place.
                        pending_s     = pending_r & tick_s;
                    end else begin
                        pending_s     = 1'b0;
                    end
                end
                ST_LD_MONTH: begin
                    shadow_month_s = databus[3:0];
                    state_s        = ST_LD_YEAR;
                    pending_s      = pending_r | tick_s;
                end
                ST_LD_YEAR: begin
                    shadow_year_s = databus;
                    state_s       = ST_VALIDATE;
                    pending_s     = pending_r | tick_s;
                end
                ST_VALIDATE: begin
                    date_s    = commit_date_s;
                    month_s   = commit_month_s;
                    year_s    = shadow_year_r;
                    state_s   = ST_IDLE;
                    pending_s = pending_r | tick_s;
                end
                default: begin
                    state_s   = ST_IDLE;
                    pending_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; asynchronous clear_n restores reset values.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r        <= ST_IDLE;
            shadow_date_r  <= 5'd0;
            shadow_month_r <= 4'd0;
            shadow_year_r  <= 6'd0;
            pending_r      <= 1'b0;
            date_r         <= RESET_DATE;
            month_r        <= RESET_MONTH;
            year_r         <= RESET_YEAR;
            month_carry_r  <= 1'b0;
            year_carry_r   <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            shadow_date_r  <= shadow_date_s;
            shadow_month_r <= shadow_month_s;
            shadow_year_r  <= shadow_year_s;
            pending_r      <= pending_s;
            date_r         <= date_s;
            month_r        <= month_s;
            year_r         <= year_s;
            month_carry_r  <= month_carry_s;
            year_carry_r   <= year_carry_s;
            busy_r         <= (state_s != ST_IDLE);
        end
    end

    assign date        = date_r;
    assign month       = month_r;
    assign year        = year_r;
    assign month_carry = month_carry_r;
    assign year_carry  = year_carry_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_calendar_date_unit.sv
// Self-checking bench for calendar_date_unit. A behavioural reference model
// steps on every rising edge and pushes the expected outputs to a scoreboard
// queue; a monitor pops and compares them just after each edge. Directed
// scenarios additionally check known constant results at key points.
module tb_calendar_date_unit;

    logic       clk;
    logic       clear_n;
    logic       clear;
    logic       load;
    logic       enable;
    logic [5:0] databus;
    logic       day_carry;
    logic [4:0] date;
    logic [3:0] month;
    logic [5:0] year;
    logic       month_carry;
    logic       year_carry;
    logic       busy;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    typedef struct {
        int d;
        int m;
        int y;
        int mc;
        int yc;
        int bsy;
    } exp_t;

    exp_t sb_q[$];

    calendar_date_unit dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .clear       (clear),
        .load        (load),
        .enable      (enable),
        .databus     (databus),
        .day_carry   (day_carry),
        .date        (date),
        .month       (month),
        .year        (year),
        .month_carry (month_carry),
        .year_carry  (year_carry),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks_cnt++;
        if (obs != exp_v) begin
            failures_cnt++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int days_tab [0:12] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    function automatic int mlen(input int mo, input int yr);
        int l;
        l = days_tab[(mo >= 0 && mo <= 12) ? mo : 0];
`ifdef CAL_LEAP_YEAR_EN
        if (mo == 2 && (yr % 4) == 0) l = 29;
`endif
        return l;
    endfunction

    int m_state, m_sd, m_sm, m_sy, m_pend;
    int m_date, m_month, m_year, m_mc, m_yc;

    initial begin
        m_state = 0; m_sd = 0; m_sm = 0; m_sy = 0; m_pend = 0;
        m_date = 1; m_month = 1; m_year = 0; m_mc = 0; m_yc = 0;
        forever begin
            @(posedge clk or negedge clear_n);
            if (!clear_n) begin
                m_state = 0; m_sd = 0; m_sm = 0; m_sy = 0; m_pend = 0;
                m_date = 1; m_month = 1; m_year = 0; m_mc = 0; m_yc = 0;
                if (clk) sb_q.push_back('{m_date, m_month, m_year, 0, 0, 0});
            end else begin
                int tick;
                int len;
                int cm;
                tick = (day_carry && enable) ? 1 : 0;
                m_mc = 0;
                m_yc = 0;
                if (clear) begin
                    m_state = 0; m_sd = 0; m_sm = 0; m_sy = 0; m_pend = 0;
                    m_date = 1; m_month = 1; m_year = 0;
                end else if (m_state == 0) begin
                    if (load) begin
                        m_sd = int'(databus[4:0]);
                        m_state = 1;
                        if (tick == 1) m_pend = 1;
                    end else if (m_pend == 1 || tick == 1) begin
                        m_pend = (m_pend == 1 && tick == 1) ? 1 : 0;
                        len = mlen(m_month, m_year);
                        if (m_date < len) begin
                            m_date = m_date + 1;
                        end else begin
                            m_date = 1;
                            m_mc = 1;
                            if (m_month == 12) begin
                                m_month = 1;
                                if (m_year == 63) begin
                                    m_year = 0;
                                    m_yc = 1;
                                end else begin
                                    m_year = m_year + 1;
                                end
                            end else begin
                                m_month = m_month + 1;
                            end
                        end
                    end
                end else begin
                    if (tick == 1) m_pend = 1;
                    if (m_state == 1) begin
                        m_sm = int'(databus[3:0]);
                        m_state = 2;
                    end else if (m_state == 2) begin
                        m_sy = int'(databus);
                        m_state = 3;
                    end else begin
                        cm = (m_sm == 0 || m_sm > 12) ? 1 : m_sm;
                        len = mlen(cm, m_sy);
                        m_month = cm;
                        m_year = m_sy;
                        m_date = (m_sd == 0) ? 1 : ((m_sd > len) ? len : m_sd);
                        m_state = 0;
                    end
                end
                sb_q.push_back('{m_date, m_month, m_year, m_mc, m_yc,
                                 (m_state != 0) ? 1 : 0});
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 0, 1);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_date",  int'(date),        e.d);
                check_val("sb_month", int'(month),       e.m);
                check_val("sb_year",  int'(year),        e.y);
                check_val("sb_mcar",  int'(month_carry), e.mc);
                check_val("sb_ycar",  int'(year_carry),  e.yc);
                check_val("sb_busy",  int'(busy),        e.bsy);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic ld, input logic en, input logic dc, input int bus);
        @(negedge clk);
        load      = ld;
        enable    = en;
        day_carry = dc;
        databus   = 6'(bus);
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic load_seq(input int d, input int m, input int y);
        drive(1'b1, 1'b1, 1'b0, d);
        drive(1'b0, 1'b1, 1'b0, m);
        drive(1'b0, 1'b1, 1'b0, y);
        idle();
    endtask

    // Checks the outputs settled by the previous edge, then drives idle inputs.
    task automatic peek(input string tag, input int d, input int m, input int y,
                        input int mc, input int yc);
        @(negedge clk);
        check_val({tag, "_date"},  int'(date),        d);
        check_val({tag, "_month"}, int'(month),       m);
        check_val({tag, "_year"},  int'(year),        y);
        check_val({tag, "_mcar"},  int'(month_carry), mc);
        check_val({tag, "_ycar"},  int'(year_carry),  yc);
        load      = 1'b0;
        enable    = 1'b1;
        day_carry = 1'b0;
        databus   = 6'd0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        clear_n   = 1'b0;
        clear     = 1'b0;
        load      = 1'b0;
        enable    = 1'b1;
        databus   = 6'd0;
        day_carry = 1'b0;
        repeat (3) @(negedge clk);
        clear_n = 1'b1;
        peek("reset", 1, 1, 0, 0, 0);

        // Load with date clamped to April's 30 days; busy covered by scoreboard.
        load_seq(31, 4, 5);
        peek("ld_apr", 30, 4, 5, 0, 0);

        // February boundary in a leap-eligible year.
        load_seq(28, 2, 4);
        peek("feb_ld", 28, 2, 4, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
`ifdef CAL_LEAP_YEAR_EN
        peek("feb29", 29, 2, 4, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
`endif
        peek("mar1", 1, 3, 4, 1, 0);
        peek("mar1_hold", 1, 3, 4, 0, 0);

        // Year wrap.
        load_seq(31, 12, 63);
        peek("dec31", 31, 12, 63, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        peek("wrap", 1, 1, 0, 1, 1);
        peek("wrap_hold", 1, 1, 0, 0, 0);

        // Tick during LD_YEAR is deferred until the first IDLE edge.
        drive(1'b1, 1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 1'b0, 6);
        drive(1'b0, 1'b1, 1'b1, 7);
        idle();
        peek("commit_pend", 10, 6, 7, 0, 0);
        peek("pend_applied", 11, 6, 7, 0, 0);

        // Tick with enable low is discarded.
        drive(1'b0, 1'b0, 1'b1, 0);
        peek("en_off", 11, 6, 7, 0, 0);

        // Zero month and zero date commit as 1/1.
        load_seq(0, 0, 9);
        peek("zero_ld", 1, 1, 9, 0, 0);

        // Feb 29 load in a leap year, and Feb 31 in a common year.
        load_seq(29, 2, 8);
`ifdef CAL_LEAP_YEAR_EN
        peek("feb29_ld", 29, 2, 8, 0, 0);
`else
        peek("feb29_ld", 28, 2, 8, 0, 0);
`endif
        load_seq(31, 2, 1);
        peek("feb31_ld", 28, 2, 1, 0, 0);

        // Pending tick plus a fresh tick at the first IDLE edge: two increments.
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b1, 3);
        drive(1'b0, 1'b1, 1'b1, 20);
        drive(1'b0, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        idle();
        peek("pend_plus", 5, 3, 20, 0, 0);

        // Synchronous clear wins over load.
        @(negedge clk);
        clear = 1'b1;
        load  = 1'b1;
        databus = 6'd17;
        @(negedge clk);
        clear = 1'b0;
        load  = 1'b0;
        peek("sclear", 1, 1, 0, 0, 0);

        // Asynchronous reset mid-load, observed without an edge.
        load_seq(15, 7, 30);
        drive(1'b1, 1'b1, 1'b0, 22);
        @(negedge clk);
        load = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        check_val("arst_date",  int'(date),  1);
        check_val("arst_month", int'(month), 1);
        check_val("arst_year",  int'(year),  0);
        check_val("arst_busy",  int'(busy),  0);
        @(negedge clk);
        clear_n = 1'b1;

        // Random traffic; the scoreboard checks every cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load      = ($urandom_range(0, 9) == 0);
            enable    = ($urandom_range(0, 4) != 0);
            day_carry = ($urandom_range(0, 2) != 0);
            databus   = 6'($urandom_range(0, 63));
            clear     = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        load = 1'b0; day_carry = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/calendar_date_unit.md
Name: calendar_date_unit

Overview:
- Calendar stage directly downstream of the day counter; consumes its day-rollover carry (one pulse per midnight).
- Maintains date (1..31), month (1..12) and year offset (0..63, meaning 2000..2063), with correct month lengths and leap years.
- Registers are loaded from the shared 6-bit databus via a three-beat load sequence.
- Produces month and year carries for display and alarm logic.

Parameters:
- RESET_DATE, 1, date value after reset or clear (must be 1..28)
- RESET_MONTH, 1, month value after reset or clear (must be 1..12)
- RESET_YEAR, 0, year offset after reset or clear (0..63)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- clear_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear to reset values
- load  in  1  start strobe for the load sequence; beat 1 captures the date
- enable  in  1  counting enable; gates day_carry
- databus  in  6  shared load data
- day_carry  in  1  one-cycle day-rollover pulse from the day counter
- date  out  5  current date, 1..31
- month  out  4  current month, 1..12
- year  out  6  current year offset, 0..63
- month_carry  out  1  one-cycle pulse on month rollover
- year_carry  out  1  one-cycle pulse on year wrap 63->0
- busy  out  1  high while a load sequence is in progress

Behaviour:
- clear_n low (asynchronous):
  - date=RESET_DATE, month=RESET_MONTH, year=RESET_YEAR
  - FSM=IDLE; busy=0; month_carry=0; year_carry=0; pending=0; shadow registers=0
- clear=1 at a clock edge: same values as reset. Priority is clear over load, and load over counting.
- All outputs are registered.
- A tick is day_carry=1 with enable=1. day_carry with enable=0 is discarded.
- FSM states: IDLE, LD_MONTH, LD_YEAR, VALIDATE.
  - IDLE + load=1: shadow_date<=databus[4:0]; go to LD_MONTH.
  - LD_MONTH: shadow_month<=databus[3:0]; go to LD_YEAR.
  - LD_YEAR: shadow_year<=databus[5:0]; go to VALIDATE.
  - VALIDATE: commit the shadows; go to IDLE.
    - Month 0 or >12 commits as 1.
    - Date 0 commits as 1.
    - Date greater than the month length (using the committed month and year) commits as that month length.
  - busy=1 in LD_MONTH, LD_YEAR and VALIDATE. load is ignored while busy.
- Tick handling:
  - A tick in IDLE with load=0 increments the calendar on that edge.
  - A tick in any other state, or coincident with load in IDLE, sets the 1-bit pending flag. A second tick while pending is already set is lost.
  - In IDLE with pending=1 and no load, one increment is applied and pending is cleared.
  - If a new tick also arrives in that cycle, pending stays set and is consumed the next cycle.
- Month length:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February is 29 if leap, else 28; leap means year[1:0]==0.
- Increment:
  - If date < length: date+1.
  - Else date=1, month_carry=1, and:
    - if month==12: month=1 and year+1; when year was 63 it wraps to 0 and year_carry=1;
    - otherwise month+1.
- Pulses are high for exactly the one cycle after the updating edge; otherwise 0.
- Latency: a tick sampled at edge N is visible on the outputs after edge N.

Optional Feature:
- Macro: CAL_LEAP_YEAR_EN
- Defined: February length is 29 when year[1:0]==0, as above.
- Undefined: February is always 28; VALIDATE clamps a Feb-29 load to 28; leap logic is absent from the netlist.

Test Plan:
- clear_n low mid-operation -> date=1, month=1, year=0, busy=0 without waiting for a clock edge.
- load with databus 31, 4, 5 on consecutive cycles -> busy high for 3 cycles, then date=30, month=4, year=5.
- Start at 28/2/year 4 with macro defined; two ticks -> 29/2, then 1/3 with a one-cycle month_carry. Without the macro, one tick -> 1/3.
- Start at 31/12/63; one tick -> 1/1/0, with month_carry and year_carry both pulsed in the same cycle.
- Tick asserted during LD_YEAR with load data 10, 6, 7 -> commit 10/6/7, then 11/6/7 on the first IDLE edge.
- Tick with enable=0 -> no change and no pulses. Load with month=0, date=0 -> committed as 1/1.
